// File: rtl/serial_word_receiver_if.sv
// Handshake/bus bundle between a framed serial source and the word receiver.
interface serial_word_receiver_if #(
  parameter int WIDTH = 16
);
  logic             sin;
  logic             sin_en;
  logic             lsb_first;
  logic             word_ack;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output sin, sin_en, lsb_first, word_ack,
    input  word, word_valid, busy, frame_err, overrun
  );

  modport slave (
    input  sin, sin_en, lsb_first, word_ack,
    output word, word_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Framed serial receiver: start(0), WIDTH data bits, stop(1); rebuilds the word
// in either bit order and hands it off on a valid/ack handshake.
module serial_word_receiver #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_word_receiver_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sreg_q, sreg_n;
  logic [WIDTH-1:0] word_q, word_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             lsb_q, lsb_n;
  logic             wv_q, wv_n;
  logic             ferr_q, ferr_n;
  logic             ovr_q, ovr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
      wv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      sreg_q  <= sreg_n;
      word_q  <= word_n;
      cnt_q   <= cnt_n;
      lsb_q   <= lsb_n;
      wv_q    <= wv_n;
      ferr_q  <= ferr_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sreg_n  = sreg_q;
    word_n  = word_q;
    cnt_n   = cnt_q;
    lsb_n   = lsb_q;
    wv_n    = wv_q;
    ferr_n  = 1'b0;
    ovr_n   = ovr_q;

    if (wv_q && bus.word_ack) wv_n = 1'b0;

    if (bus.sin_en) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.sin) begin
            state_n = DATA;
            cnt_n   = '0;
            lsb_n   = bus.lsb_first;
          end
        end
        DATA: begin
          sreg_n = lsb_q ? {bus.sin, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], bus.sin};
          cnt_n  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_n = STOP;
        end
        STOP: begin
          // A low stop bit is an error only; it never doubles as the next start bit.
          state_n = IDLE;
          if (!bus.sin) begin
            ferr_n = 1'b1;
          end else if (!wv_q || bus.word_ack) begin
            word_n = sreg_q;
            wv_n   = 1'b1;
          end else begin
            ovr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = wv_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench: stimulus pushes expected words / frame errors, a negedge
// monitor pops them whenever the receiver delivers a word or flags an error.
module tb_serial_word_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  serial_word_receiver_if #(.WIDTH(16)) bus ();

  serial_word_receiver #(.WIDTH(16), .CNT_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: a delivery is word_valid high now while it was low, or acked, last cycle.
  logic pv = 1'b0, pack = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.word_valid && (!pv || pack)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h expected none", bus.word);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_err || bus.word !== e.data) begin
            errors++;
            $display("FAIL word: got %h expected %h (err_expected=%0d)", bus.word, e.data, e.is_err);
          end
        end
      end
      if (bus.frame_err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          exp_t e;
          e = q.pop_front();
          if (!e.is_err) begin
            errors++;
            $display("FAIL frame_err: got 1 expected word %h", e.data);
          end
        end
      end
    end
    pv   = bus.word_valid;
    pack = bus.word_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.sin    = b;
    bus.sin_en = 1'b1;
    tick();
    bus.sin_en = 1'b0;
    bus.sin    = 1'b1;
    repeat (gap - 1) tick();
  endtask

  // seq[15] goes on the wire first; lsb_first is flipped mid-frame and must be ignored.
  task automatic send_frame(input logic [15:0] seq, input logic lsb, input logic stopb,
                            input int gap, input logic ack_stop, input int kind,
                            input logic [15:0] expw);
    exp_t e;
    e.is_err = (kind == 2);
    e.data   = expw;
    if (kind != 0) q.push_back(e);
    bus.lsb_first = lsb;
    send_bit(1'b0, gap);
    bus.lsb_first = ~lsb;
    for (int i = 15; i >= 0; i--) send_bit(seq[i], gap);
    bus.sin      = stopb;
    bus.sin_en   = 1'b1;
    bus.word_ack = ack_stop;
    tick();
    bus.sin_en    = 1'b0;
    bus.sin       = 1'b1;
    bus.word_ack  = 1'b0;
    bus.lsb_first = lsb;
  endtask

  task automatic ack();
    bus.word_ack = 1'b1;
    tick();
    bus.word_ack = 1'b0;
  endtask

  initial begin
    bus.sin       = 1'b1;
    bus.sin_en    = 1'b0;
    bus.lsb_first = 1'b0;
    bus.word_ack  = 1'b0;
    repeat (3) tick();
    chk("rst_word", 32'(bus.word), 32'h0);
    chk("rst_outs", {bus.word_valid, bus.busy, bus.frame_err, bus.overrun}, 0);
    rst_n = 1'b1;
    tick();

    // 1: MSB first
    send_frame(16'b1010010111000011, 1'b0, 1'b1, 1, 1'b0, 1, 16'hA5C3);
    chk("t1_word", 32'(bus.word), 32'hA5C3);
    chk("t1_valid", bus.word_valid, 1);
    chk("t1_ferr", bus.frame_err, 0);
    ack();
    chk("t1_ack_clears", bus.word_valid, 0);

    // 2: LSB first, same wire sequence
    send_frame(16'b1010010111000011, 1'b1, 1'b1, 1, 1'b0, 1, 16'hC3A5);
    chk("t2_word", 32'(bus.word), 32'hC3A5);
    chk("t2_busy", bus.busy, 0);
    ack();
    chk("t2_ack_clears", bus.word_valid, 0);
    chk("t2_word_hold", 32'(bus.word), 32'hC3A5);
    ack();
    chk("t2_idle_ack", bus.word_valid, 0);

    // 3: bad stop bit, then a good frame
    send_frame(16'h1234, 1'b0, 1'b0, 1, 1'b0, 2, 16'h0);
    chk("t3_ferr_pulse", bus.frame_err, 1);
    chk("t3_no_word", bus.word_valid, 0);
    tick();
    chk("t3_ferr_1cyc", bus.frame_err, 0);
    chk("t3_not_start", bus.busy, 0);
    send_frame(16'h1234, 1'b0, 1'b1, 1, 1'b0, 1, 16'h1234);
    chk("t3_word", 32'(bus.word), 32'h1234);
    ack();

    // 4: overrun, then delivery on an ack edge
    send_frame(16'h00FF, 1'b0, 1'b1, 1, 1'b0, 1, 16'h00FF);
    send_frame(16'hFFFF, 1'b0, 1'b1, 1, 1'b0, 0, 16'h0);
    chk("t4_overrun", bus.overrun, 1);
    chk("t4_word_kept", 32'(bus.word), 32'h00FF);
    chk("t4_valid_kept", bus.word_valid, 1);
    send_frame(16'hFFFF, 1'b0, 1'b1, 1, 1'b1, 1, 16'hFFFF);
    chk("t4_word_new", 32'(bus.word), 32'hFFFF);
    chk("t4_valid_new", bus.word_valid, 1);
    chk("t4_overrun_sticky", bus.overrun, 1);
    ack();

    // 5: idle strobes, gapped strobe frame
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, 3);
      chk("t5_idle_busy", bus.busy, 0);
    end
    bus.lsb_first = 1'b0;
    send_bit(1'b0, 3);
    chk("t5_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5_overrun_rst", bus.overrun, 0);
    send_frame(16'h8001, 1'b0, 1'b1, 3, 1'b0, 1, 16'h8001);
    chk("t5_word", 32'(bus.word), 32'h8001);

    // 6: reset after 7 data bits, then a full frame
    send_bit(1'b0, 1);
    for (int i = 0; i < 7; i++) send_bit(i[0], 1);
    chk("t6_busy_mid", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_word", 32'(bus.word), 32'h0);
    chk("t6_rst_outs", {bus.word_valid, bus.busy, bus.frame_err, bus.overrun}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(16'h5AA5, 1'b0, 1'b1, 1, 1'b0, 1, 16'h5AA5);
    chk("t6_word", 32'(bus.word), 32'h5AA5);
    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
